// File: rtl/mac_neuron_fsm.sv
// Single-neuron MAC engine: accumulates N_INPUTS signed 8x8 products into a saturating
// 16-bit sum and exposes it with a ReLU view; sequenced IDLE -> LOAD -> MAC -> DONE.
module mac_neuron_fsm #(
  parameter int unsigned N_INPUTS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [7:0]  x,
  input  logic signed [7:0]  w,
  output logic signed [15:0] acc,
  output logic signed [15:0] relu_out,
  output logic               done_out
);

  localparam int unsigned CntW = $clog2(N_INPUTS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_INPUTS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StMac, StDone} state_e;

  state_e             state_q, state_d;
  logic signed [15:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic signed [15:0] prod;
  logic signed [16:0] sum;
  logic signed [15:0] sum_sat;

  // Operands sign-extended first, so -128 * -128 = 16384 is exact.
  assign prod = 16'(x) * 16'(w);
  assign sum  = 17'(acc_q) + 17'(prod);

  always_comb begin
    sum_sat = sum[15:0];
    if (sum[16] != sum[15]) begin
      sum_sat = sum[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StMac;
      end
      StMac: begin
        acc_d = sum_sat;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc      = acc_q;
    done_out = (state_q == StDone);
    relu_out = (acc_q > 0) ? acc_q : '0;
  end

endmodule

// File: tb/tb_mac_neuron_fsm.sv
// Directed bench for mac_neuron_fsm: a sum-of-products model tracks the expected outputs
// and a negedge process compares them every cycle, backed by literal result checks.
module tb_mac_neuron_fsm;

  localparam int N = 3;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [7:0]  x;
  logic signed [7:0]  w;
  logic signed [15:0] acc;
  logic signed [15:0] relu_out;
  logic               done_out;

  int n_cmp = 0;
  int n_err = 0;
  int exp_acc = 0;
  bit exp_done = 0;

  mac_neuron_fsm #(.N_INPUTS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .w        (w),
    .acc      (acc),
    .relu_out (relu_out),
    .done_out (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int relu(input int v);
    return (v > 0) ? v : 0;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("acc", int'(acc), exp_acc);
    check("relu_out", int'(relu_out), relu(exp_acc));
    check("done_out", int'(done_out), int'(exp_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_xw();
    x = 8'($urandom);
    w = 8'($urandom);
  endtask

  // One full transaction; start is driven in the current (IDLE) cycle.
  task automatic run(input int xs[N], input int ws[N], input bit start_in_mac);
    start = 1'b1;
    randomize_xw();
    tick();               // edge 0: start sampled
    start = 1'b1;         // ignored in LOAD
    randomize_xw();
    tick();               // edge 1: LOAD clears acc
    exp_acc = 0;
    for (int k = 0; k < N; k++) begin
      x = 8'(xs[k]);
      w = 8'(ws[k]);
      start = start_in_mac && (k == 1);
      tick();
      exp_acc = sat16(exp_acc + xs[k] * ws[k]);
      if (k == N - 1) exp_done = 1'b1;
    end
    start = 1'b0;
    randomize_xw();
    tick();               // edge N+2: back to IDLE
    exp_done = 1'b0;
  endtask

  task automatic idle(input int cycles);
    start = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      randomize_xw();
      tick();
    end
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    exp_acc = 0;
    exp_done = 1'b0;
    #1;
    check("reset_acc", int'(acc), 0);
    check("reset_done", int'(done_out), 0);
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    x = '0;
    w = '0;
    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      randomize_xw();
      tick();
    end
    check("reset_acc_lit", int'(acc), 0);
    check("reset_relu_lit", int'(relu_out), 0);
    rst = 1'b1;
    idle(3);
    check("idle_done_lit", int'(done_out), 0);

    // Positive sum.
    run('{2, 3, 4}, '{5, 6, 7}, 1'b0);
    idle(3);
    check("pos_acc_lit", int'(acc), 56);
    check("pos_relu_lit", int'(relu_out), 56);

    // Negative sum after an async reset.
    async_reset();
    run('{-2, -3, -4}, '{5, 6, 7}, 1'b0);
    idle(2);
    check("neg_acc_lit", int'(acc), -56);
    check("neg_relu_lit", int'(relu_out), 0);

    // Saturation both ways.
    run('{-128, -128, -128}, '{-128, -128, -128}, 1'b0);
    check("satpos_acc_lit", int'(acc), 32767);
    check("satpos_relu_lit", int'(relu_out), 32767);
    idle(1);
    run('{-128, -128, -128}, '{127, 127, 127}, 1'b0);
    check("satneg_acc_lit", int'(acc), -32768);
    check("satneg_relu_lit", int'(relu_out), 0);

    // start during MAC is ignored; next runs start in the first IDLE cycle.
    run('{2, 3, 4}, '{5, 6, 7}, 1'b1);
    check("restart_acc_lit", int'(acc), 56);
    run('{2, -2, 0}, '{3, 3, 7}, 1'b0);
    check("zero_acc_lit", int'(acc), 0);
    check("zero_relu_lit", int'(relu_out), 0);

    // Mid-run reset after the second MAC cycle.
    run('{2, 3, 4}, '{5, 6, 7}, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    exp_acc = 0;
    x = 8'sd10; w = 8'sd10; tick(); exp_acc = 100;
    x = 8'sd10; w = 8'sd10; tick(); exp_acc = 200;
    async_reset();
    idle(2);
    run('{2, 3, 4}, '{5, 6, 7}, 1'b0);
    idle(2);
    check("postreset_acc_lit", int'(acc), 56);
    check("postreset_relu_lit", int'(relu_out), 56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
